// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length and state enums, Nk/Nr constants,
// round-key buffer sizing and GF(2^8) helpers.
// Build option: define AES_LONG_KEY_EN to enable 192- and 256-bit keys.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        FIN    = 2'd3
    } state_e;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 6;

    localparam int unsigned NK_128 = 4;
    localparam int unsigned NK_192 = 6;
    localparam int unsigned NK_256 = 8;
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

`ifdef AES_LONG_KEY_EN
    localparam int unsigned BUF_DEPTH = 60;
    localparam int unsigned WIN_DEPTH = 8;
    localparam int unsigned KEY_W     = 256;
`else
    localparam int unsigned BUF_DEPTH = 44;
    localparam int unsigned WIN_DEPTH = 4;
    localparam int unsigned KEY_W     = 128;
`endif

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Byte-wide forward AES S-box: multiplicative inverse followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] sub
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // x^254 is the inverse for non-zero x and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    assign inv = gf_inv(a);
    assign sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_expander.sv
// Word-serial AES key schedule engine with an on-chip round-key buffer.
// Build option: AES_LONG_KEY_EN adds 192/256-bit modes; without it only AES-128 exists.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    output logic [3:0]   nr,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    state_e              state_q;
    logic [KEY_W-1:0]    key_q;
    logic [WORD_W-1:0]   win_q [WIN_DEPTH];
    logic [ADDR_W-1:0]   i_q;
    logic [7:0]          rcon_q;
    logic [WORD_W-1:0]   buf_q [BUF_DEPTH];

    logic [WORD_W-1:0]   w_prev;
    logic [WORD_W-1:0]   w_back;
    logic [WORD_W-1:0]   sub_in;
    logic [WORD_W-1:0]   sub_out;
    logic [WORD_W-1:0]   temp;
    logic [WORD_W-1:0]   new_word;
    logic [ADDR_W-1:0]   load_last;
    logic [ADDR_W-1:0]   exp_last;
    logic                at_rcon;
    logic                at_sub_only;
    logic                wr_en;
    logic                accept;

`ifdef AES_LONG_KEY_EN
    logic [2:0]          nk_m1_q;
    logic [2:0]          mod_q;
    logic [3:0]          nr_q;

    assign nr          = nr_q;
    assign w_back      = win_q[nk_m1_q];
    assign at_rcon     = (mod_q == 3'd0);
    assign at_sub_only = (nk_m1_q == 3'(NK_256 - 1)) && (mod_q == 3'd4);
    assign load_last   = ADDR_W'(nk_m1_q);
    assign exp_last    = {nr_q, 2'b11};
`else
    logic                unused_inputs;

    assign unused_inputs = ^{key_len, key_in[255-KEY_W:0]};
    assign nr          = 4'(NR_128);
    assign w_back      = win_q[NK_128-1];
    assign at_rcon     = (i_q[1:0] == 2'd0);
    assign at_sub_only = 1'b0;
    assign load_last   = ADDR_W'(NK_128 - 1);
    assign exp_last    = ADDR_W'(4 * (NR_128 + 1) - 1);
`endif

    assign accept = !rst && (state_q == IDLE) && start;
    assign wr_en  = (state_q == LOAD) || (state_q == EXPAND);
    assign w_prev = win_q[0];
    assign sub_in = at_rcon ? rot_word(w_prev) : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a   (sub_in[8*b +: 8]),
            .sub (sub_out[8*b +: 8])
        );
    end

    // Select the schedule temp word for the current position in the Nk cycle.
    always_comb begin
        temp = w_prev;
        if (at_rcon) begin
            temp = sub_out ^ {rcon_q, 24'h000000};
        end else if (at_sub_only) begin
            temp = sub_out;
        end
    end

    assign new_word = (state_q == LOAD) ? key_q[KEY_W-1 -: WORD_W] : (w_back ^ temp);

    // Control FSM: sequencing, word counter, rcon and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
            i_q      <= '0;
            rcon_q   <= 8'h01;
`ifdef AES_LONG_KEY_EN
            nk_m1_q  <= 3'(NK_128 - 1);
            nr_q     <= 4'(NR_128);
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        busy     <= 1'b1;
                        rk_valid <= 1'b0;
                        i_q      <= '0;
                        rcon_q   <= 8'h01;
`ifdef AES_LONG_KEY_EN
                        case (key_len)
                            KEY_192: begin
                                nk_m1_q <= 3'(NK_192 - 1);
                                nr_q    <= 4'(NR_192);
                            end
                            KEY_256: begin
                                nk_m1_q <= 3'(NK_256 - 1);
                                nr_q    <= 4'(NR_256);
                            end
                            default: begin
                                nk_m1_q <= 3'(NK_128 - 1);
                                nr_q    <= 4'(NR_128);
                            end
                        endcase
`endif
                    end
                end
                LOAD: begin
                    i_q <= i_q + ADDR_W'(1);
                    if (i_q == load_last) begin
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    i_q <= i_q + ADDR_W'(1);
                    if (at_rcon) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (i_q == exp_last) begin
                        state_q  <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rk_valid <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Key shifter, sliding window of recent words and modulo-Nk counter.
    always_ff @(posedge clk) begin
        if (accept) begin
            key_q <= key_in[255 -: KEY_W];
`ifdef AES_LONG_KEY_EN
            mod_q <= 3'd0;
`endif
        end else if (wr_en) begin
            key_q    <= key_q << WORD_W;
            win_q[0] <= new_word;
            for (int k = WIN_DEPTH - 1; k > 0; k--) begin
                win_q[k] <= win_q[k-1];
            end
`ifdef AES_LONG_KEY_EN
            mod_q <= (mod_q == nk_m1_q) ? 3'd0 : mod_q + 3'd1;
`endif
        end
    end

    // Round-key buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[i_q] <= new_word;
        end
    end

    logic [ADDR_W-1:0] rd_base;
    logic [127:0]      rd_word_c;

    assign rd_base   = {rk_idx, 2'b00};
    assign rd_word_c = {buf_q[rd_base],               buf_q[rd_base + ADDR_W'(1)],
                        buf_q[rd_base + ADDR_W'(2)],  buf_q[rd_base + ADDR_W'(3)]};

    if (RD_LAT == 0) begin : g_rd_comb
        assign rk_out = rd_word_c;
    end else begin : g_rd_reg
        // Registered round-key read.
        always_ff @(posedge clk) begin
            if (rst) begin
                rk_out <= '0;
            end else begin
                rk_out <= rd_word_c;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander with a behavioural key-schedule model.
module tb_aes_key_expander;

    localparam logic [127:0] A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] A2   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_LONG_KEY_EN
    localparam int LAT192 = 53;
    localparam int LAT256 = 61;
    localparam int NR192  = 12;
    localparam int NR256  = 14;
`else
    localparam int LAT192 = 45;
    localparam int LAT256 = 45;
    localparam int NR192  = 10;
    localparam int NR256  = 10;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   nr;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [256];
    logic [31:0]  pend_w [60];
    int           pend_nr;
    logic [127:0] rk_exp [15];

    bit           m_busy;
    bit           m_done;
    bit           m_valid;
    bit           m_prev_valid;
    int           m_left;
    int           m_nr = 10;
    logic [3:0]   m_idx;

    always #5 clk = ~clk;

    aes_key_expander #(.RD_LAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .rk_valid (rk_valid),
        .nr       (nr),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int x = 0; x < 8; x++) if (b[x]) p = p ^ (15'(a) << x);
        for (int x = 14; x >= 8; x--) if (p[x]) p = p ^ (15'(9'h11b) << (x - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int j = 0; j < 8; j++)
                s[j] = inv[j] ^ inv[(j+4)%8] ^ inv[(j+5)%8] ^ inv[(j+6)%8] ^ inv[(j+7)%8] ^ c[j];
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int n = 1; n < j; n++) r = gmul(r, 8'h02);
        return r;
    endfunction

    task automatic model_expand(input logic [255:0] k, input logic [1:0] kl);
        int nk;
        int nrm;
        int sel;
        logic [31:0] t;
        sel = int'(kl);
`ifndef AES_LONG_KEY_EN
        sel = 0;
`endif
        nk = 4; nrm = 10;
        if (sel == 1) begin nk = 6; nrm = 12; end
        else if (sel == 2) begin nk = 8; nrm = 14; end
        for (int i = 0; i < nk; i++) pend_w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nrm + 1); i++) begin
            t = pend_w[i-1];
            if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_word(t);
            pend_w[i] = pend_w[i-nk] ^ t;
        end
        pend_nr = nrm;
    endtask

    // Transaction-level reference: start acceptance, word count, completion.
    always @(posedge clk) begin
        m_prev_valid = m_valid;
        m_idx = rk_idx;
        if (rst) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_left = 0; m_nr = 10;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_valid = 1;
                for (int r = 0; r < 15; r++)
                    rk_exp[r] = {pend_w[4*r], pend_w[4*r+1], pend_w[4*r+2], pend_w[4*r+3]};
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            model_expand(key_in, key_len);
            m_nr = pend_nr;
            m_left = 4 * (pend_nr + 1);
            m_busy = 1;
            m_valid = 0;
        end
    end

    // Per-cycle comparison of all outputs against the reference.
    always @(posedge clk) begin
        #1;
        check("busy", 128'(busy), 128'(m_busy));
        check("done", 128'(done), 128'(m_done));
        check("rk_valid", 128'(rk_valid), 128'(m_valid));
        check("nr", 128'(nr), 128'(m_nr));
        if (m_prev_valid && m_valid && m_idx <= 4'(m_nr))
            check($sformatf("rk_out[%0d]", m_idx), rk_out, rk_exp[m_idx]);
    end

    task automatic run(input logic [255:0] k, input logic [1:0] kl, input int exp_lat,
                       input int exp_nr, input int pulse_at, input string tag);
        int lat;
        @(negedge clk);
        key_in = k; key_len = kl; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == pulse_at);
            if (lat == pulse_at) begin key_in = ~k; key_len = 2'd2; end
            if (lat == 1) begin
                check({tag, "_busy_on"}, 128'(busy), 128'(1));
                check({tag, "_valid_off"}, 128'(rk_valid), 128'(0));
                check({tag, "_nr"}, 128'(nr), 128'(exp_nr));
            end
        end while (!done && lat < 100);
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_valid_on"}, 128'(rk_valid), 128'(1));
    endtask

    task automatic read_rk(input int idx, output logic [127:0] v);
        @(negedge clk); rk_idx = 4'(idx);
        @(negedge clk); v = rk_out;
    endtask

    initial begin
        logic [127:0] v;
        int done_seen;
        rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rk_idx = 4'd0;
        build_sbox();
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_nr", 128'(nr), 128'(10));
        check("rst_rk_out", rk_out, 128'h0);
        rst = 1'b0;

        // A.1 with garbage in the ignored low key bits
        run({A1, 128'h0123456789abcdeffedcba9876543210}, 2'd0, 45, 10, 0, "a1");
        check("model_rk1", rk_exp[1], RK1);
        check("model_rk10", rk_exp[10], RK10);
        read_rk(1, v);  check("a1_rk1", v, RK1);
        read_rk(10, v); check("a1_rk10", v, RK10);

        // Read-latency sweep: output must still show the previous index right after a change
        @(negedge clk); rk_idx = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rk_idx = 4'(k);
            #1;
            check($sformatf("lag_%0d", k), rk_out, rk_exp[k-1]);
            if (k == 1) check("rk0_is_key", rk_out, A1);
        end

        // Ignored start while busy, then back-to-back A.3 the cycle after done
        @(negedge clk); rk_idx = 4'd10;
        run({A1, 128'h0}, 2'd0, 45, 10, 10, "a1_pulse");
        run(A3, 2'd2, LAT256, NR256, 0, "a3");
`ifdef AES_LONG_KEY_EN
        check("model_rk14_lo", 128'(rk_exp[14][31:0]), 128'(32'h706c631e));
        read_rk(14, v); check("a3_rk14_lo", 128'(v[31:0]), 128'(32'h706c631e));
`endif

        run({A2, 64'h0}, 2'd1, LAT192, NR192, 0, "a2");
`ifdef AES_LONG_KEY_EN
        read_rk(12, v); check("a2_rk12_lo", 128'(v[31:0]), 128'(32'h01002202));
`endif

        // Abort an AES-256 run at cycle 20, then rerun A.1
        @(negedge clk); key_in = A3; key_len = 2'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_valid", 128'(rk_valid), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        done_seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", 128'(done_seen), 128'(0));
        run({A1, 128'h0}, 2'd0, 45, 10, 0, "a1_rerun");
        read_rk(1, v);  check("rerun_rk1", v, RK1);
        read_rk(10, v); check("rerun_rk10", v, RK10);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential, parametrised AES key-schedule engine: accepts a 128/192/256-bit cipher key, expands it word-serially into the full round-key set, and stores all round keys in an internal buffer. The cipher datapath reads any round key by index. It replaces per-round combinational key generation in the AES-over-UART datapath. One 32-bit schedule word is produced per clock, and four shared S-boxes are used for SubWord.

## Interface
- `RD_LAT`, default 1: round-key read latency in cycles. Legal values are 0 (combinational read) and 1 (registered read).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin expansion. Sampled only in IDLE.
- `key_len`  in  2  key length: 0=128, 1=192, 2=256, 3=reserved (treated as 128). Latched with `start`.
- `key_in`  in  256  cipher key, MSB-first. A 128-bit key occupies [255:128] and a 192-bit key occupies [255:64]. Unused low bits are ignored. Latched with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the last word is written.
- `done`  out  1  one-cycle pulse after the last word is written.
- `rk_valid`  out  1  high when a complete schedule is in the buffer.
- `nr`  out  4  round count of the stored schedule: 10, 12 or 14.
- `rk_idx`  in  4  round-key index to read, 0..nr.
- `rk_out`  out  128  round key `rk_idx`, equal to words w[4i]..w[4i+3] with w[4i] in [127:96].

## Operation
- **States:** IDLE, LOAD, EXPAND, FIN.
  - IDLE: `start`=1 latches the key and mode, clears `rk_valid`, and moves to LOAD. The word counter `i` is set to 0 and `rcon` to 8'h01.
  - LOAD: writes key word `i` to buffer address `i`, one per cycle, for Nk cycles (Nk = 4, 6 or 8). Then moves to EXPAND.
  - EXPAND: computes w[i] = w[i-Nk] ^ temp, one per cycle, for i = Nk .. 4(Nr+1)-1. `temp` is defined as:
    - if i mod Nk = 0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon ← xtime(rcon), with reduction by 8'h1b;
    - if Nk=8 and i mod 8 = 4: SubWord(w[i-1]);
    - otherwise: w[i-1].
  - After writing word 4(Nr+1)-1, moves to FIN.
  - FIN: asserts `done` for one cycle, sets `rk_valid`, and returns to IDLE.
- w[i-1] and w[i-Nk] are held in an 8-word sliding shift register, so the buffer needs no extra read port during expansion.
- The buffer is 60×32. Only addresses 0..4(Nr+1)-1 are meaningful.
- i mod Nk is tracked by a separate modulo counter. No divider is used.
- `start` while busy or in FIN is ignored.
- `nr` updates when the key is latched.
- Reading while `rk_valid`=0, or with `rk_idx` > `nr`, returns undefined data. No error is flagged.

## Timing
- `start` is sampled at edge 0. Word i is written at edge i+1. `done` is high in the cycle after edge 4(Nr+1).
- Start-to-`done` latency: 45 cycles for AES-128, 53 for AES-192, 61 for AES-256.
- A new `start` is accepted in the cycle after `done`.
- With RD_LAT=1, `rk_out` reflects `rk_idx` sampled at the previous edge. With RD_LAT=0, it reflects the current `rk_idx`.
- **Reset values:** `busy`=0, `done`=0, `rk_valid`=0, `nr`=10, `rk_out`=0 (RD_LAT=1), state IDLE, rcon 8'h01.
- Buffer contents are not cleared by reset.
- `rst` mid-expansion aborts at once: IDLE, `rk_valid`=0, no `done`.
- `rst` and `start` in the same cycle: reset wins.

## Configuration
- Macro `AES_LONG_KEY_EN`:
  - Defined: 192- and 256-bit modes are supported as above.
  - Undefined: `key_len` is ignored and always treated as 128. The buffer shrinks to 44 words and the shift register to 4 words. The Nk=8 SubWord path and the modulo-Nk counter are removed, and `nr` is constant 10.

## Structure
- **Shared package `aes_pkg`:**
  - key-length enum, Nk/Nr lookup constants, state enum;
  - `xtime` function, RotWord function, buffer depth constant (60 or 44).
- **Sub-module `aes_sbox`:** byte-wide forward S-box, combinational. Four instances form SubWord. It is shared with the cipher datapath.

## Test plan
- **FIPS-197 A.1 key** (2b7e151628aed2a6abf7158809cf4f3c), `key_len`=0:
  - `done` is expected 45 cycles after `start`;
  - `rk_idx`=1 → a0fafe1788542cb123a339392a6c7605;
  - `rk_idx`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- **FIPS-197 A.2 key** (8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b), `key_len`=1:
  - `nr`=12 and `done` at 53 cycles;
  - rk[12][31:0] = 01002202.
- **FIPS-197 A.3 key** (603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4), `key_len`=2:
  - `nr`=14 and `done` at 61 cycles;
  - rk[14][31:0] = 706c631e.
- **Abort and re-run:** assert `rst` at cycle 20 of an AES-256 run.
  - Expect `busy`=0, `rk_valid`=0 and no `done`.
  - A following A.1 run must reproduce the A.1 results exactly, confirming `rcon` restarted at 01.
- **Back-to-back and ignored start:** pulse `start` again while busy. It must be ignored, with `done` still at cycle 45 and the A.1 keys intact. Issue `start` the cycle after `done` with the A.3 key; `rk_valid` must fall, then rise with the A.3 results.
- **Read latency:** with RD_LAT=1, sweep `rk_idx` 0..10 one per cycle. `rk_out` must lag by exactly one cycle, with rk[0] equal to the A.1 key.
